// File: rtl/fp_classify_sched_if.sv
// Operand request bus and classified-result handoff bus of fp_classify_sched.
// The scheduler connects through the slave modport and the operand sources through master.
interface fp_classify_sched_if #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4
);
    localparam int ID_W = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  out_valid;
    logic                  out_ready;
    logic [ID_W-1:0]       out_id;
    logic [WIDTH-1:0]      out_data;
    logic [9:0]            out_class;

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_id, out_data, out_class
    );

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_id, out_data, out_class
    );
endinterface

// File: rtl/fp_classify_sched.sv
// Round-robin sharing of one IEEE-754 classifier among NREQ operand sources.
// Results go to a one-entry output register, and a saturating counter tracks handed-off snans.
module fp_classify_sched #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    fp_classify_sched_if.slave bus,
    input  logic               cnt_clr,
    output logic [CNT_W-1:0]   snan_cnt
);
    localparam int ID_W  = $clog2(NREQ);
    localparam int EXP_W = (WIDTH == 64) ? 11 : (WIDTH == 32) ? 8 : 5;
    localparam int MAN_W = WIDTH - 1 - EXP_W;

    // Class bit order: snan, qnan, -inf, -norm, -denorm, -0, +0, +denorm, +norm, +inf.
    function automatic logic [9:0] classify(input logic [WIDTH-1:0] v);
        logic             sign;
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] m;
        logic [9:0]       c;
        sign = v[WIDTH-1];
        e    = v[WIDTH-2 -: EXP_W];
        m    = v[MAN_W-1:0];
        c    = '0;
        if (&e) begin
            if (m != '0) begin
                if (m[MAN_W-1]) c[1] = 1'b1;
                else            c[0] = 1'b1;
            end else if (sign) c[2] = 1'b1;
            else               c[9] = 1'b1;
        end else if (e == '0) begin
            if (m == '0) begin
                if (sign) c[5] = 1'b1;
                else      c[6] = 1'b1;
            end else if (sign) c[4] = 1'b1;
            else               c[7] = 1'b1;
        end else if (sign) c[3] = 1'b1;
        else               c[8] = 1'b1;
        return c;
    endfunction

    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  gidx;
    logic             found;
    logic             load;
    logic             accept;
    logic [WIDTH-1:0] sel_data;
    logic [ID_W-1:0]  ptr_next;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin : arb
        logic [ID_W:0] s;
        found = 1'b0;
        gidx  = '0;
        s     = '0;
        for (int k = 0; k < NREQ; k++) begin
            s = {1'b0, ptr} + (ID_W+1)'(k);
            if (s >= (ID_W+1)'(NREQ)) s = s - (ID_W+1)'(NREQ);
            if (!found && bus.req_valid[s[ID_W-1:0]]) begin
                found = 1'b1;
                gidx  = s[ID_W-1:0];
            end
        end
    end

    always_comb begin
        load          = !bus.out_valid || bus.out_ready;
        accept        = load && found && !rst;
        sel_data      = bus.req_data[gidx*WIDTH +: WIDTH];
        ptr_next      = (gidx == ID_W'(NREQ-1)) ? '0 : gidx + 1'b1;
        bus.req_ready = '0;
        if (accept) bus.req_ready[gidx] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_id    <= '0;
            bus.out_data  <= '0;
            bus.out_class <= '0;
            snan_cnt      <= '0;
            ptr           <= '0;
        end else begin
            if (load) begin
                bus.out_valid <= accept;
                if (accept) begin
                    bus.out_id    <= gidx;
                    bus.out_data  <= sel_data;
                    bus.out_class <= classify(sel_data);
                    ptr           <= ptr_next;
                end
            end
            // Clear beats a coincident increment; the count sticks at all-ones.
            if (cnt_clr)
                snan_cnt <= '0;
            else if (bus.out_valid && bus.out_ready && bus.out_class[0] && snan_cnt != '1)
                snan_cnt <= snan_cnt + 1'b1;
        end
    end
endmodule

// File: doc/fp_classify_sched.md
Name: fp_classify_sched

Overview:
Round-robin scheduler that shares one combinational fp_classify instance among NREQ requesters. Each requester offers a valid/ready operand. The granted operand is classified and registered into a single-entry output stage, tagged with its requester ID. A saturating counter tracks signaling-NaN events. The block sits between per-lane operand sources and a shared exception/status collector.

Parameters:
WIDTH, 16, IEEE-754 operand width; legal values are 16, 32 and 64.
NREQ, 4, number of requesters; range 2..16.
ID_W, $clog2(NREQ), requester ID width (localparam).
CNT_W, 16, width of the signaling-NaN event counter.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
req_valid  in  NREQ  bit i: requester i is offering an operand.
req_data  in  NREQ*WIDTH  operand i occupies bits [i*WIDTH +: WIDTH].
req_ready  out  NREQ  one-hot or zero; bit i: operand i is accepted this cycle.
out_valid  out  1  output register holds a result.
out_ready  in  1  downstream accepts the result.
out_id  out  ID_W  requester index of the held result.
out_data  out  WIDTH  held operand, passed through unchanged.
out_class  out  10  one-hot class: [0] snan, [1] qnan, [2] neg_inf, [3] neg_normal, [4] neg_denormal, [5] neg_zero, [6] pos_zero, [7] pos_denormal, [8] pos_normal, [9] pos_inf.
snan_cnt  out  CNT_W  saturating count of snan results handed off.
cnt_clr  in  1  synchronous clear of snan_cnt.

Behaviour:
- Reset (rst=1 at a clock edge) sets: out_valid=0, out_id=0, out_data=0, out_class=0, snan_cnt=0, round-robin pointer ptr=0. req_ready is combinationally 0 while rst=1.
- rst has priority over all other inputs. Reset mid-transfer discards the held result; no handshake is reported for it.
- load = !out_valid || out_ready. The output stage can accept in the same cycle it drains (full throughput, 1 result/cycle).
- Arbitration is combinational. The grant goes to the first i with req_valid[i]=1, searching ptr, ptr+1, ... modulo NREQ.
- req_ready[g] = load && any(req_valid) && not rst, for granted index g only. All other req_ready bits are 0.
- req_ready never depends on req_data. It may depend on req_valid.
- On an accept (req_valid[g] && req_ready[g]) at a clock edge:
  - out_valid<=1, out_id<=g, out_data<=req_data[g], out_class<=classification of req_data[g].
  - ptr<=(g+1) mod NREQ, wrapping from NREQ-1 back to 0.
- If load=1 with no request: out_valid<=0, ptr unchanged, and out_data/out_id/out_class hold their last values.
- If load=0 (out_valid=1, out_ready=0): all output registers hold, req_ready=0, ptr holds.
- Latency is 1 cycle from accept edge to out_valid=1. The result stays stable until out_valid && out_ready.
- Classification follows IEEE-754:
  - exp all ones, mantissa non-zero: NaN; mantissa MSB=1 gives qnan, otherwise snan.
  - exp all ones, mantissa zero: inf.
  - exp zero, mantissa zero: zero.
  - exp zero, mantissa non-zero: denormal.
  - anything else: normal.
  - Sign selects neg/pos for non-NaN classes. NaN classes ignore sign.
- out_class is exactly one-hot whenever out_valid=1.
- snan_cnt increments when out_valid && out_ready && out_class[0]. It saturates at 2^CNT_W-1 and never wraps.
- If cnt_clr and an increment occur in the same cycle, the result is 0 (clear wins).
- Requesters may deassert req_valid without a handshake. The scheduler does not latch unaccepted requests.

Test Plan:
1. Reset, then a single requester. rst=1 for 2 cycles, then req_valid=4'b0100, data2=16'h3C00, out_ready=1 → next cycle: out_valid=1, out_id=2, out_class[8]=1, ptr=3.
2. Round-robin fairness, all lanes valid. req_valid=4'b1111 continuously, out_ready=1, data lanes 0..3 = 16'h7C00, 16'hFC00, 16'h8000, 16'h0001 → out_id sequence 0,1,2,3,0; class bits 9,2,5,7 respectively; one result per cycle.
3. Backpressure. Hold out_ready=0 for 5 cycles with lane 1 offering 16'h7E00 → req_ready=0 throughout; out_valid, out_id=1 and out_class[1] stable. Raise out_ready → drain and the next accept occur in the same cycle.
4. Pointer wrap and skipping. ptr=3, req_valid=4'b0010 → grant lane 1, ptr becomes 2. Then req_valid=4'b1001 → grant lane 3, ptr becomes 0.
5. snan counting. Send lane 0 data 16'h7D00 ×3 with out_ready=1 → snan_cnt=3. Send 16'h7E00 → no change. Assert cnt_clr together with an snan handoff → snan_cnt=0. Preload to 16'hFFFF, then one more snan → stays 16'hFFFF.
6. Reset mid-operation and WIDTH=32. out_valid=1 with out_ready=0, assert rst → next cycle out_valid=0, snan_cnt=0. For WIDTH=32: 32'h7F800001 → snan, 32'h80000000 → neg_zero, 32'h00400000 → pos_denormal.
